// File: rtl/data_mem_block_dma.sv
// Block DMA between valid/ready streams and a 1024x32 single-port data memory (LOAD / UNLOAD).
// Optional feature: define DATA_MEM_DMA_CHECKSUM_EN to add a wrapping 32-bit checksum output.
module data_mem_block_dma #(
    parameter int MEM_AW = 10,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dir,
    input  logic [MEM_AW-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [MEM_AW-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
`ifdef DATA_MEM_DMA_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(64);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNLOAD, S_DONE} state_t;

    state_t            state_reg;
    logic [MEM_AW-1:0] base_reg;
    logic [MEM_AW-1:0] wr_addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  acc_cnt_reg;
    logic [LEN_W-1:0]  issue_cnt_reg;
    logic [LEN_W-1:0]  pop_cnt_reg;
    logic              wr_pend_reg;
    logic [31:0]       wr_data_reg;
    logic              rd_infl_reg;
    logic [31:0]       fifo_mem_reg [2];
    logic              fifo_wr_ptr_reg;
    logic              fifo_rd_ptr_reg;
    logic [1:0]        fifo_cnt_reg;

    logic [LEN_W-1:0]  len_clamped;
    logic              accept;
    logic              pop;
    logic              rd_issue;
    logic [2:0]        fifo_occ;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign in_ready    = (state_reg == S_LOAD) && (acc_cnt_reg < len_reg);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (fifo_cnt_reg != 2'd0);
    assign out_data    = fifo_mem_reg[fifo_rd_ptr_reg];
    assign pop         = out_valid && out_ready;

    // Reads in flight count against FIFO space so a stalled sink never overflows it.
    assign fifo_occ = {1'b0, fifo_cnt_reg} + {2'b00, rd_infl_reg};
    assign rd_issue = (state_reg == S_UNLOAD) && (issue_cnt_reg < len_reg)
                      && (fifo_occ < (3'd2 + {2'b00, pop}));

    assign mem_chipselect = wr_pend_reg || rd_issue;
    assign mem_write      = wr_pend_reg;
    assign mem_address    = rd_issue ? (base_reg + MEM_AW'(issue_cnt_reg)) : wr_addr_reg;
    assign mem_writedata  = wr_data_reg;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            acc_cnt_reg   <= '0;
            issue_cnt_reg <= '0;
            pop_cnt_reg   <= '0;
            wr_pend_reg   <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            rd_infl_reg   <= 1'b0;
        end else begin
            wr_pend_reg <= accept;
            if (accept) begin
                wr_addr_reg <= base_reg + MEM_AW'(acc_cnt_reg);
                wr_data_reg <= in_data;
            end
            rd_infl_reg <= rd_issue;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        base_reg      <= base_addr;
                        len_reg       <= len_clamped;
                        acc_cnt_reg   <= '0;
                        issue_cnt_reg <= '0;
                        pop_cnt_reg   <= '0;
                        state_reg     <= dir ? S_UNLOAD : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) acc_cnt_reg <= acc_cnt_reg + LEN_W'(1);
                    // Once every word is accepted, the pending write is the last one.
                    if (len_reg == '0 || (acc_cnt_reg == len_reg && wr_pend_reg))
                        state_reg <= S_DONE;
                end
                S_UNLOAD: begin
                    if (rd_issue) issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
                    if (pop) pop_cnt_reg <= pop_cnt_reg + LEN_W'(1);
                    if (len_reg == '0 || (pop && (pop_cnt_reg + LEN_W'(1)) == len_reg))
                        state_reg <= S_DONE;
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem_reg[0] <= '0;
            fifo_mem_reg[1] <= '0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
        end else begin
            if (rd_infl_reg) begin
                fifo_mem_reg[fifo_wr_ptr_reg] <= mem_readdata;
                fifo_wr_ptr_reg               <= ~fifo_wr_ptr_reg;
            end
            if (pop) fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, rd_infl_reg} - {1'b0, pop};
        end
    end

`ifdef DATA_MEM_DMA_CHECKSUM_EN
    logic [31:0] checksum_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            checksum_reg <= '0;
        end else if (wr_pend_reg) begin
            checksum_reg <= checksum_reg + wr_data_reg;
        end else if (pop) begin
            checksum_reg <= checksum_reg + out_data;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule
